// File: rtl/tdm_slot_scheduler_pkg.sv
// tdm_pkg: shared defaults and FSM state type for the TDM slot scheduler.
//   N_CH_DEF    - default channel count (power of two)
//   SEL_W_DEF   - default select width, log2(N_CH_DEF)
//   DWELL_W_DEF - default width of the dwell configuration input
//   state_e     - scheduler FSM states
package tdm_pkg;

  localparam int unsigned N_CH_DEF    = 8;
  localparam int unsigned SEL_W_DEF   = 3;
  localparam int unsigned DWELL_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_scheduler_rr_next_sel.sv
// rr_next_sel: circular priority encoder.
// Returns the first set bit of req at or after index start, wrapping
// around past N_CH-1 back to 0.
//   req      - request mask
//   start    - index where the search begins
//   next_idx - selected index (equals start when nothing is found)
//   found    - high when req has any bit set
module rr_next_sel #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] next_idx,
  output logic             found
);

  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] ofs;

  always_comb begin
    // Rotating the doubled mask right by start puts channel 'start' at bit 0,
    // so a plain lowest-bit-first scan yields the circular winner.
    rot   = N_CH'({req, req} >> start);
    found = 1'b0;
    ofs   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (rot[i] && !found) begin
        ofs   = SEL_W'(i);
        found = 1'b1;
      end
    end
    next_idx = start + ofs;
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: time-division controller for a shared 1-bit serial line
// between an N_CH:1 mux and a 1:N_CH demux. Grants slots round-robin to
// requesting channels only, holds each slot for a programmable dwell, and
// latches the received bit into a per-channel hold register at slot end.
//   clk         - system clock, rising edge
//   rst         - asynchronous reset, active-high
//   en          - scheduler enable (checked at slot boundaries)
//   req         - per-channel request mask
//   dwell       - cycles per slot, 0 treated as 1, captured at slot start
//   line_in     - serial bit from the mux output
//   sel         - select to mux and demux
//   sel_valid   - high while a slot is active
//   frame_start - pulse on the first cycle of a slot that begins a new round
//   hold_out    - latched per-channel data
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int unsigned N_CH    = N_CH_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               line_in,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               frame_start,
  output logic [N_CH-1:0]    hold_out
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   sel_d;
  logic               sel_valid_d;
  logic               frame_start_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]    hold_d;
  logic [DWELL_W-1:0] dwell_eff;
  logic [SEL_W-1:0]   search_start;
  logic [SEL_W-1:0]   nxt_idx;
  logic               nxt_found;
  logic               slot_end;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // While in a slot, last_q equals sel, so one search from last+1 serves
  // both the IDLE entry and the back-to-back slot hand-off.
  assign search_start = last_q + SEL_W'(1);

  rr_next_sel #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_next_sel (
    .req      (req),
    .start    (search_start),
    .next_idx (nxt_idx),
    .found    (nxt_found)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    sel_d         = sel;
    sel_valid_d   = sel_valid;
    frame_start_d = 1'b0;
    cnt_d         = cnt_q;
    hold_d        = hold_out;
    slot_end      = 1'b0;

    case (state_q)
      IDLE: ;
      SLOT: begin
        if (!req[sel]) begin
          // Request dropped: abort without sampling.
          slot_end = 1'b1;
        end else if (cnt_q == '0) begin
          hold_d[sel] = line_in;
          slot_end    = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: ;
    endcase

    if (state_q == IDLE || slot_end) begin
      if (en && nxt_found) begin
        state_d       = SLOT;
        sel_d         = nxt_idx;
        last_d        = nxt_idx;
        sel_valid_d   = 1'b1;
        cnt_d         = dwell_eff - DWELL_W'(1);
        frame_start_d = (state_q == IDLE) || (nxt_idx <= sel);
      end else begin
        state_d     = IDLE;
        sel_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= SEL_W'(N_CH - 1);
      sel         <= '0;
      sel_valid   <= 1'b0;
      frame_start <= 1'b0;
      cnt_q       <= '0;
      hold_out    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel         <= sel_d;
      sel_valid   <= sel_valid_d;
      frame_start <= frame_start_d;
      cnt_q       <= cnt_d;
      hold_out    <= hold_d;
    end
  end

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed testbench for tdm_slot_scheduler with a behavioural reference
// model feeding an expected-value queue.
module tb_tdm_slot_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] dwell;
  logic       line_in;
  logic [2:0] sel;
  logic       sel_valid;
  logic       frame_start;
  logic [7:0] hold_out;

  int compared   = 0;
  int mismatched = 0;

  tdm_slot_scheduler #(
    .N_CH    (8),
    .SEL_W   (3),
    .DWELL_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .dwell       (dwell),
    .line_in     (line_in),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .frame_start (frame_start),
    .hold_out    (hold_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       sv;
    logic       fs;
    logic [7:0] hold;
  } exp_t;

  exp_t q[$];

  // reference model state
  bit         m_slot;
  logic [2:0] m_sel;
  logic [2:0] m_last;
  int         m_cnt;
  logic [7:0] m_hold;
  logic       m_sv;
  logic       m_fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] find_next(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    find_next = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) find_next = idx;
    end
  endfunction

  task automatic model_reset();
    m_slot = 1'b0; m_sel = 3'd0; m_last = 3'd7; m_cnt = 0;
    m_hold = 8'h00; m_sv = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_grant(input logic [2:0] nx, input logic fs);
    m_slot = 1'b1; m_sel = nx; m_last = nx; m_sv = 1'b1; m_fs = fs;
    m_cnt  = (dwell == 8'd0) ? 0 : int'(dwell) - 1;
  endtask

  task automatic model_edge();
    logic [2:0] nx;
    bit         ends;
    ends = 1'b0;
    m_fs = 1'b0;
    if (!m_slot) begin
      if (en && req != 8'h00) model_grant(find_next(req, m_last + 3'd1), 1'b1);
    end else begin
      if (!req[m_sel]) ends = 1'b1;
      else if (m_cnt == 0) begin
        m_hold[m_sel] = line_in;
        ends = 1'b1;
      end else m_cnt--;
      if (ends) begin
        if (en && req != 8'h00) begin
          nx = find_next(req, m_sel + 3'd1);
          model_grant(nx, nx <= m_sel);
        end else begin
          m_slot = 1'b0; m_sv = 1'b0;
        end
      end
    end
  endtask

  // One clock: predict, push, wait the edge, pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    e.sel = m_sel; e.sv = m_sv; e.fs = m_fs; e.hold = m_hold;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sel", 32'(sel), 32'(e.sel));
    chk("sel_valid", 32'(sel_valid), 32'(e.sv));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("hold_out", 32'(hold_out), 32'(e.hold));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_hold", 32'(hold_out), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin : stim
    logic [2:0] t1_sel [6];
    logic       t1_fs  [6];
    bit         hit;
    t1_sel = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
    t1_fs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; en = 1'b0; req = 8'h00; dwell = 8'd0; line_in = 1'b0;
    @(posedge clk); #1;
    do_reset();
    step();  // idle with no request stays idle

    // two requesters, dwell 2
    en = 1'b1; req = 8'b0000_0101; dwell = 8'd2; line_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_sel_seq", 32'(sel), 32'(t1_sel[i]));
      chk("t1_fs_seq", 32'(frame_start), 32'(t1_fs[i]));
      if (i == 4) chk("t1_hold", 32'(hold_out), 32'h05);
    end

    // single requester, dwell 0, toggling line
    do_reset();
    req = 8'h80; dwell = 8'd0; line_in = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      line_in = ~line_in;
      step();
      chk("t2_sel", 32'(sel), 32'd7);
      chk("t2_fs", 32'(frame_start), 32'd1);
      chk("t2_hold7", 32'(hold_out[7]), 32'(line_in));
    end

    // request drop mid-slot on ch3
    do_reset();
    req = 8'hFF; dwell = 8'd3; line_in = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("t3_hold3_pre", 32'(hold_out[3]), 32'd1);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (m_slot && m_sel == 3'd3 && m_cnt == 1) hit = 1'b1;
      else step();
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $error("FAIL t3_wait: observed timeout expected ch3 second cycle");
    end
    line_in = 1'b0; req = 8'hF7;
    step();
    chk("t3_next_sel", 32'(sel), 32'd4);
    chk("t3_hold3", 32'(hold_out[3]), 32'd1);
    step();

    // en dropped mid-slot on ch1, dwell 4
    do_reset();
    req = 8'h02; dwell = 8'd4; line_in = 1'b1; en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    step();
    step();
    chk("t4_sel", 32'(sel), 32'd1);
    chk("t4_sv", 32'(sel_valid), 32'd0);
    chk("t4_hold1", 32'(hold_out[1]), 32'd1);
    step();

    // reset in the 3rd cycle of a dwell-5 slot
    en = 1'b1; req = 8'h01; dwell = 8'd5;
    step();
    chk("t5_grant", 32'(sel), 32'd0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_sel", 32'(sel), 32'd0);
    chk("t5_rst_sv", 32'(sel_valid), 32'd0);
    chk("t5_rst_hold", 32'(hold_out), 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    req = 8'h10;
    step();
    chk("t5_first_sel", 32'(sel), 32'd4);
    chk("t5_first_fs", 32'(frame_start), 32'd1);

    // dwell changed mid-slot
    do_reset();
    req = 8'h01; dwell = 8'd2; line_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) dwell = 8'd6;
      if (i == 3) chk("t6_fs_s2", 32'(frame_start), 32'd1);
      if (i == 8) chk("t6_fs_mid", 32'(frame_start), 32'd0);
      if (i == 9) chk("t6_fs_s3", 32'(frame_start), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tdm_slot_scheduler.md
Name: tdm_slot_scheduler

Overview:
- Time-division controller for the shared 1-bit serial line between the 8:1 input mux and the 3-to-8 output demux.
- Replaces the free-running select counter: grants slots round-robin only to requesting channels, holds each slot for a programmable dwell, then latches the received bit into a per-channel hold register so outputs stay steady between visits.

Parameters:
- N_CH, 8, number of channels (power of two).
- SEL_W, 3, select width, log2(N_CH).
- DWELL_W, 8, width of the dwell configuration input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  scheduler enable.
- req  input  N_CH  per-channel request mask.
- dwell  input  DWELL_W  cycles per slot; 0 is treated as 1.
- line_in  input  1  serial bit from the mux output.
- sel  output  SEL_W  select driven to both mux and demux.
- sel_valid  output  1  high while a slot is active.
- frame_start  output  1  one-cycle pulse on the first cycle of a slot that starts a new round.
- hold_out  output  N_CH  latched per-channel data.

Behaviour:
- Reset (async): all outputs 0; internal last-granted pointer = N_CH-1, so the first search starts at channel 0; dwell counter 0; state IDLE.
- FSM states: IDLE, SLOT.
- IDLE, sel_valid=0, sel holds its last value:
  - if en && req!=0 at a clock edge, enter SLOT at that edge.
  - sel = first set req bit at or after (last+1) mod N_CH, circularly.
  - sel_valid=1 from the next cycle; latency from request to sel_valid is 1 cycle.
- Slot start:
  - D = (dwell==0) ? 1 : dwell, captured at slot start; later dwell changes are ignored until the next slot.
  - Counter loads D-1.
  - last <= granted channel.
- SLOT, each cycle:
  - counter decrements.
  - On the cycle where counter==0 and req[sel]==1: at that edge hold_out[sel] <= line_in. All other hold bits are unchanged.
  - Slot end, same edge: if en && req!=0, the next slot starts back-to-back with no gap cycle; the next channel is the first set req bit after sel, circularly. Otherwise go to IDLE.
- Single requester: the same channel is re-granted continuously, with hold updated every D cycles.
- Request drop mid-slot: if req[sel] goes 0, the slot aborts at that edge with no sample.
  - hold_out[sel] retains its value.
  - Next-slot selection follows the same rule as a normal slot end.
- en deasserted mid-slot: the current slot completes, including its sample, then the FSM goes to IDLE.
- frame_start=1 during the first cycle of a slot when either:
  - the slot was entered from IDLE, or
  - the granted index <= the previous granted index (wrap, including the single-requester case).
- Hold registers are never cleared except by reset; channels not requested keep stale data.
- Reset asserted mid-slot: immediate return to reset values; no partial sample.

Decomposition:
- Package tdm_pkg holds N_CH, SEL_W, DWELL_W defaults and the FSM state enum {IDLE, SLOT}.
- One combinational sub-module, rr_next_sel: inputs req mask and start index; outputs next index and a found flag (circular priority encoder via double-width mask).
- The FSM, dwell counter and hold registers live in the top module.

Test Plan:
- Reset, then en=1, req=8'b0000_0101, dwell=2, line_in=1 -> sel sequence 0,0,2,2,0,0…; frame_start high on the first cycle for ch0 both times; hold_out=8'b0000_0101 after 4 slot cycles.
- dwell=0, req=8'h80, line_in toggling each cycle -> sel=7 every cycle, sel_valid=1, frame_start high every cycle, hold_out[7] follows line_in delayed 1 cycle.
- req=8'hFF, dwell=3, hold ch3 high, drop req[3] on the 2nd cycle of slot 3 -> slot 3 ends at that edge; next slot is ch4 at the following cycle; hold_out[3] unchanged.
- en=0 mid-slot on ch1 with dwell=4 -> slot completes with hold_out[1] sampled; sel_valid=0 on the next cycle; sel stays 1.
- Assert rst during the 3rd cycle of a dwell=5 slot -> sel=0, sel_valid=0, hold_out=0 immediately; after release with req=8'h10, the first grant is ch4 with frame_start=1.
- Change dwell from 2 to 6 during a slot -> current slot lasts 2 cycles; the next lasts 6.
